// File: rtl/cpu54_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: state encoding,
// default timing parameters and a counter-width helper.
package cpu54_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_PAUSE = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10
   } state_e;

   localparam int unsigned DEF_DEB_CYCLES = 32'd1000000;
   localparam int unsigned DEF_SLOW_DIV   = 32'd262144;
   localparam int unsigned DEF_FAST_DIV   = 32'd64;
   localparam int unsigned DEF_CNT_W      = 32'd32;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned ctr_w(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 32'd1);
      if (w < 32'd1) begin
         w = 32'd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter: the debounced level
// only follows the input after DEB_CYCLES consecutive disagreeing cycles.
module btn_debounce
   import cpu54_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic level_o
);

   localparam int unsigned CW = ctr_w(DEB_CYCLES);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any agreeing cycle restarts the stability window.
   always_comb begin
      level_d = level_q;
      cnt_d   = {CW{1'b0}};
      if (sync2_q == level_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == CW'(DEB_CYCLES - 32'd1)) begin
         level_d = sync2_q;
         cnt_d   = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns run switch, step button and speed switch into a
// single-cycle CPU clock enable and counts the retired steps.
module cpu_step_ctrl
   import cpu54_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned SLOW_DIV   = DEF_SLOW_DIV,
   parameter int unsigned FAST_DIV   = DEF_FAST_DIV,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sw_run,
   input  logic             btn_step,
   input  logic             sw_fast,
   output logic             cpu_en,
   output logic [CNT_W-1:0] step_cnt,
   output logic [1:0]       mode
);

   localparam int unsigned PW = ctr_w((SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV);

   logic             run_db;
   logic             btn_db;
   logic             btn_db_prev_q;
   logic             step_req_q;
   logic             fast_s1_q;
   logic             fast_s2_q;
   logic             fast_prev_q;
   logic             fast_chg;
   logic [PW-1:0]    div_m1;
   logic             tick;
   state_e           state_q;
   state_e           state_d;
   logic [PW-1:0]    presc_q;
   logic [PW-1:0]    presc_d;
   logic             cpu_en_q;
   logic             cpu_en_d;
   logic [CNT_W-1:0] step_cnt_q;
   logic [CNT_W-1:0] step_cnt_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_db (
      .clk_i   (clk_in),
      .reset_i (reset),
      .async_i (sw_run),
      .level_o (run_db)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_db (
      .clk_i   (clk_in),
      .reset_i (reset),
      .async_i (btn_step),
      .level_o (btn_db)
   );

   assign fast_chg = fast_s2_q ^ fast_prev_q;
   assign div_m1   = fast_s2_q ? PW'(FAST_DIV - 32'd1) : PW'(SLOW_DIV - 32'd1);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         fast_s1_q     <= 1'b0;
         fast_s2_q     <= 1'b0;
         fast_prev_q   <= 1'b0;
         btn_db_prev_q <= 1'b0;
         step_req_q    <= 1'b0;
         state_q       <= ST_PAUSE;
         presc_q       <= {PW{1'b0}};
         cpu_en_q      <= 1'b0;
         step_cnt_q    <= {CNT_W{1'b0}};
      end else begin
         fast_s1_q     <= sw_fast;
         fast_s2_q     <= fast_s1_q;
         fast_prev_q   <= fast_s2_q;
         btn_db_prev_q <= btn_db;
         step_req_q    <= btn_db & ~btn_db_prev_q;
         state_q       <= state_d;
         presc_q       <= presc_d;
         cpu_en_q      <= cpu_en_d;
         step_cnt_q    <= step_cnt_d;
      end
   end

   // Prescaler only runs in RUN; dropping run or a speed change kills the tick.
   always_comb begin
      state_d = state_q;
      presc_d = {PW{1'b0}};
      tick    = 1'b0;
      case (state_q)
         ST_PAUSE: begin
            if (run_db) begin
               state_d = ST_RUN;
            end else if (step_req_q) begin
               state_d = ST_STEP;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_STEP: begin
            state_d = ST_PAUSE;
         end
         ST_RUN: begin
            if (!run_db) begin
               state_d = ST_PAUSE;
            end else if (fast_chg) begin
               presc_d = {PW{1'b0}};
            end else if (presc_q >= div_m1) begin
               tick = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         default: begin
            state_d = ST_PAUSE;
         end
      endcase

      cpu_en_d = (state_q == ST_STEP) | tick;
      if (cpu_en_d) begin
         step_cnt_d = step_cnt_q + CNT_W'(1);
      end else begin
         step_cnt_d = step_cnt_q;
      end
   end

   assign cpu_en   = cpu_en_q;
   assign step_cnt = step_cnt_q;
   assign mode     = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomised and directed bench for cpu_step_ctrl against a behavioural model
// of the run/step rules, plus hand-computed latency and count expectations.
module tb_cpu_step_ctrl;

   localparam int DEB  = 4;
   localparam int SLOW = 8;
   localparam int FAST = 2;
   localparam int CW   = 8;

   logic          clk_in   = 1'b0;
   logic          reset    = 1'b1;
   logic          sw_run   = 1'b0;
   logic          btn_step = 1'b0;
   logic          sw_fast  = 1'b0;
   logic          cpu_en;
   logic [CW-1:0] step_cnt;
   logic [1:0]    mode;

   int total = 0;
   int bad   = 0;

   always #5 clk_in = ~clk_in;

   cpu_step_ctrl #(
      .DEB_CYCLES (DEB),
      .SLOW_DIV   (SLOW),
      .FAST_DIV   (FAST),
      .CNT_W      (CW)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .sw_run   (sw_run),
      .btn_step (btn_step),
      .sw_fast  (sw_fast),
      .cpu_en   (cpu_en),
      .step_cnt (step_cnt),
      .mode     (mode)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Inputs seen by the logic are the raw pins two samples late; a level is
   // accepted once it has disagreed with the accepted level DEB times in a row.
   bit r_pipe[2], b_pipe[2], f_pipe[2];
   bit f_seen;
   bit r_lvl, b_lvl, b_lvl_old, step_pending;
   int r_run_len, b_run_len;
   int m_mode;     // 0 pause, 1 run, 2 step
   int phase;      // cycles spent in the current RUN period
   bit m_en;
   int m_cnt;

   task automatic accept(input bit seen, inout bit lvl, inout int run_len);
      if (seen == lvl) run_len = 0;
      else if (run_len + 1 == DEB) begin lvl = seen; run_len = 0; end
      else run_len = run_len + 1;
   endtask

   task automatic model_step();
      bit en;
      int nmode;
      int period;
      if (reset) begin
         r_pipe = '{0, 0}; b_pipe = '{0, 0}; f_pipe = '{0, 0};
         f_seen = 0; r_lvl = 0; b_lvl = 0; b_lvl_old = 0; step_pending = 0;
         r_run_len = 0; b_run_len = 0; m_mode = 0; phase = 0; m_en = 0; m_cnt = 0;
      end else begin
         en     = 0;
         nmode  = m_mode;
         period = f_pipe[1] ? FAST : SLOW;
         case (m_mode)
            0: nmode = r_lvl ? 1 : (step_pending ? 2 : 0);
            2: begin nmode = 0; en = 1; end
            1: begin
               if (!r_lvl) begin
                  nmode = 0;
                  phase = 0;
               end else if (f_pipe[1] != f_seen) begin
                  phase = 0;
               end else begin
                  phase = phase + 1;
                  if (phase == period) begin en = 1; phase = 0; end
               end
            end
            default: nmode = 0;
         endcase
         step_pending = b_lvl && !b_lvl_old;
         b_lvl_old    = b_lvl;
         accept(r_pipe[1], r_lvl, r_run_len);
         accept(b_pipe[1], b_lvl, b_run_len);
         f_seen    = f_pipe[1];
         f_pipe[1] = f_pipe[0]; f_pipe[0] = sw_fast;
         r_pipe[1] = r_pipe[0]; r_pipe[0] = sw_run;
         b_pipe[1] = b_pipe[0]; b_pipe[0] = btn_step;
         m_mode = nmode;
         m_en   = en;
         if (en) m_cnt = (m_cnt + 1) % (1 << CW);
      end
   endtask

   // Single compare process: model advances on each edge, outputs checked 1ns later.
   always @(posedge clk_in) begin
      model_step();
      #1;
      check("cpu_en", int'(cpu_en), int'(m_en));
      check("step_cnt", int'(step_cnt), m_cnt);
      check("mode", int'(mode), m_mode);
   end

   // ---------------- stimulus ----------------
   int n;
   int pulses;
   int steps_seen;
   int last_pos;
   int gap;
   int prev_cnt;
   bit wrapped;

   initial begin
      sw_run = 1'b1; btn_step = 1'b1; sw_fast = 1'b1; reset = 1'b1;
      repeat (3) begin
         @(negedge clk_in);
         check("rst_cpu_en", int'(cpu_en), 0);
         check("rst_cnt", int'(step_cnt), 0);
         check("rst_mode", int'(mode), 0);
      end
      reset = 1'b0;
      n = 0;
      while (n < 40 && mode != 2'b01) begin @(negedge clk_in); n++; end
      check("run_after_reset_latency", n, 7);
      check("no_step_when_both", int'(step_cnt), 0);

      reset = 1'b1; sw_run = 1'b0; btn_step = 1'b0; sw_fast = 1'b0;
      repeat (3) @(negedge clk_in);
      reset = 1'b0;
      repeat (10) @(negedge clk_in);

      // glitchy press: 1,0,1,0,1,0 then held 20 cycles, then released 20 cycles
      pulses = 0; steps_seen = 0;
      for (int i = 0; i < 46; i++) begin
         btn_step = (i < 6) ? 1'(~i & 1) : (i < 26);
         @(negedge clk_in);
         pulses += int'(cpu_en);
         if (mode == 2'b10) steps_seen++;
      end
      check("glitch_press_pulses", pulses, 1);
      check("glitch_press_cnt", int'(step_cnt), 1);
      check("glitch_press_step_state", steps_seen, 1);

      // clean press: sync 2 + debounce 4 + edge + step + output register
      btn_step = 1'b1;
      n = 0;
      while (n < 40 && cpu_en != 1'b1) begin @(negedge clk_in); n++; end
      check("step_latency", n, 9);
      check("step_cnt_two", int'(step_cnt), 2);
      btn_step = 1'b0;
      repeat (15) @(negedge clk_in);

      // slow run: first enable at sync+debounce+enter+8, then every 8 cycles
      sw_run = 1'b1;
      n = 0;
      while (n < 60 && cpu_en != 1'b1) begin @(negedge clk_in); n++; end
      check("run_first_latency", n, 15);
      pulses = 0;
      repeat (80) begin @(negedge clk_in); pulses += int'(cpu_en); end
      check("slow_pulses_80", pulses, 10);
      check("slow_cnt", int'(step_cnt), 13);

      sw_fast = 1'b1;
      last_pos = -1; gap = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_in);
         if (cpu_en) begin
            if (last_pos >= 0) gap = i - last_pos;
            last_pos = i;
         end
      end
      check("fast_gap", gap, 2);

      // press in RUN then pause: no step should follow
      btn_step = 1'b1; repeat (10) @(negedge clk_in);
      btn_step = 1'b0; repeat (10) @(negedge clk_in);
      sw_run = 1'b0;
      steps_seen = 0;
      repeat (20) begin @(negedge clk_in); if (mode == 2'b10) steps_seen++; end
      check("run_press_no_step", steps_seen, 0);
      check("run_press_mode", int'(mode), 0);

      // fast run until the counter wraps, then reset mid-run
      sw_run = 1'b1;
      wrapped = 1'b0;
      prev_cnt = int'(step_cnt);
      n = 0;
      while (n < 1500 && !wrapped) begin
         @(negedge clk_in); n++;
         if (prev_cnt == 255 && int'(step_cnt) == 0) wrapped = 1'b1;
         prev_cnt = int'(step_cnt);
      end
      check("cnt_wrap", int'(wrapped), 1);
      repeat (5) @(negedge clk_in);
      reset = 1'b1;
      @(negedge clk_in);
      check("midrun_rst_en", int'(cpu_en), 0);
      check("midrun_rst_cnt", int'(step_cnt), 0);
      check("midrun_rst_mode", int'(mode), 0);
      reset = 1'b0;

      // random phase
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_in);
         if ($urandom_range(0, 19) == 0) sw_run = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) sw_fast = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 11) == 0) btn_step = ~btn_step;
         reset = ($urandom_range(0, 599) == 0);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk_in);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Run/step controller upstream of the 54-instruction CPU on the board.
- Replaces the free-running divided CPU clock with a one-cycle clock enable `cpu_en`, driven by a run switch, a single-step button and a speed switch.
- Keeps a retired-step counter for the 7-segment display path.
- Runs entirely on the board clock.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable cycles needed before a debounced level updates (10 ms at 100 MHz).
- SLOW_DIV, 262144: run-mode `cpu_en` period in clk_in cycles, speed switch low.
- FAST_DIV, 64: run-mode `cpu_en` period in clk_in cycles, speed switch high.
- CNT_W, 32: width of `step_cnt`.

Ports:
- clk_in  input  1  board clock; the only clock.
- reset  input  1  synchronous reset, active-high.
- sw_run  input  1  asynchronous level; 1 requests continuous run.
- btn_step  input  1  asynchronous, bouncy push button; each press gives one step while paused.
- sw_fast  input  1  asynchronous level; selects FAST_DIV (1) or SLOW_DIV (0).
- cpu_en  output  1  registered one-cycle pulse; the CPU advances one instruction per pulse.
- step_cnt  output  CNT_W  count of `cpu_en` pulses since reset.
- mode  output  2  current state: 00 PAUSE, 01 RUN, 10 STEP.

Behaviour:
- **Reset** (synchronous, priority over everything):
  - state = PAUSE; cpu_en = 0; step_cnt = 0; mode = 00.
  - Prescaler, synchronizers and debounce counters are cleared; debounced levels = 0.
- **Synchronizers:** all three async inputs pass through 2-FF synchronizers.
- **Debounce** (sw_run, btn_step):
  - The counter counts consecutive cycles in which the synced input differs from the debounced level.
  - When the count reaches DEB_CYCLES, the debounced level takes the synced value and the counter clears.
  - Any cycle where synced equals debounced clears the counter.
  - Debounced btn_step is edge-detected; one rising edge gives a one-cycle `step_req`.
- **Prescaler:**
  - Counts 0 .. div-1, where div = sw_fast_sync ? FAST_DIV : SLOW_DIV.
  - `tick` is high on the cycle the count equals div-1; the count then wraps to 0.
  - If sw_fast_sync changes, the prescaler clears that cycle and no tick is issued.
  - The prescaler only advances in RUN; it is held at 0 in PAUSE and STEP.
- **FSM transitions:**
  - PAUSE: if run_db = 1 -> RUN (prescaler starts from 0). Else if step_req -> STEP. If both occur in the same cycle, RUN wins and the step request is discarded.
  - STEP: lasts exactly one cycle; unconditionally -> PAUSE.
  - RUN: if run_db = 0 -> PAUSE; any tick in that same cycle is suppressed. step_req is ignored in RUN.
- **Output timing:**
  - cpu_en is registered. It is 1 in the cycle after the FSM enters STEP, and in the cycle after each RUN tick. Never asserted two cycles back-to-back, since FAST_DIV >= 2 is required.
  - step_cnt increments by 1 in the same cycle cpu_en is 1, and wraps modulo 2^CNT_W.
  - mode reflects the registered state.
- **Latency:**
  - btn_step edge to cpu_en: 2 (sync) + DEB_CYCLES (debounce) + 1 (edge) + 1 (STEP) + 1 (output reg).
  - In RUN, the first cpu_en comes div cycles after entering RUN, plus 1 register cycle.
- **Boundaries:**
  - A held button produces one step only; release must debounce before the next press.
  - Reset asserted mid-RUN: cpu_en = 0 the next cycle; a pending tick is lost.
  - A button press in RUN that is released before pause does not step later.

Decomposition:
- Package `cpu54_ctrl_pkg` holds:
  - the state encoding constants (PAUSE = 2'b00, RUN = 2'b01, STEP = 2'b10);
  - default DEB_CYCLES / SLOW_DIV / FAST_DIV.
- One sub-module, `btn_debounce`: 2-FF sync + stability counter, parameter DEB_CYCLES, output debounced level. Instantiated for sw_run and btn_step.
- sw_fast uses a bare 2-FF sync in the parent.

Test Plan (DEB_CYCLES=4, SLOW_DIV=8, FAST_DIV=2, CNT_W=8):
- Reset held 3 cycles with all inputs at 1 -> cpu_en = 0, step_cnt = 0, mode = 00 throughout. After release, mode reaches 01 only after the sync+debounce delay.
- btn_step pulsed high 20 cycles with 1-cycle glitches for the first 3 cycles, sw_run = 0 -> exactly one cpu_en pulse, step_cnt = 1, mode passes 00->10->00.
- sw_run = 1, sw_fast = 0 for 80 cycles after debounce -> cpu_en every 8 cycles, step_cnt = 10. Flip sw_fast = 1 -> no tick in the switch cycle, then cpu_en every 2 cycles.
- Press btn_step during RUN, then drop sw_run -> no extra step; step_cnt equals the run-pulse count only; mode ends at 00.
- sw_run and btn_step debounce rising in the same cycle from PAUSE -> state RUN, no STEP entered, no extra cpu_en.
- In RUN at FAST, preload via 255 pulses then one more -> step_cnt wraps 255->0. Assert reset mid-RUN -> next cycle cpu_en = 0, step_cnt = 0, mode = 00.
